// File: rtl/pu4_feeder.sv
// Feeder for a four-lane processing unit: buffers a batch of input/weight
// pairs, issues them four at a time, and tags each PU result with its group.
module pu4_feeder #(
  parameter int DEPTH = 8,
  parameter int W     = 5,
  localparam int NG   = DEPTH / 4,
  localparam int IW   = (NG > 1) ? $clog2(NG) : 1,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  input  logic [W-1:0]  load_weight,
  input  logic          start,
  output logic          busy,
  output logic [W-1:0]  pu_in1,
  output logic [W-1:0]  pu_in2,
  output logic [W-1:0]  pu_in3,
  output logic [W-1:0]  pu_in4,
  output logic [W-1:0]  pu_w1,
  output logic [W-1:0]  pu_w2,
  output logic [W-1:0]  pu_w3,
  output logic [W-1:0]  pu_w4,
  input  logic [11:0]   pu_out,
  output logic          res_valid,
  output logic [11:0]   res_data,
  output logic [IW-1:0] res_index,
  output logic          done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_READY,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] g_q, g_d;

  logic [W-1:0]  in_mem_q [DEPTH];
  logic [W-1:0]  wt_mem_q [DEPTH];

  logic [W-1:0]  pu_in_q [4];
  logic [W-1:0]  pu_in_d [4];
  logic [W-1:0]  pu_w_q  [4];
  logic [W-1:0]  pu_w_d  [4];

  // valid/index pipeline: tag (on pu_in), p1, p2 (result stage)
  logic          tag_q, tag_d;
  logic [IW-1:0] tag_idx_q, tag_idx_d;
  logic          p1_q, p1_d;
  logic [IW-1:0] p1_idx_q, p1_idx_d;
  logic          p2_q, p2_d;
  logic [IW-1:0] p2_idx_q, p2_idx_d;

  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          wr_en;
  logic          last_wr;
  logic          last_grp;

  assign wr_en    = (state_q == S_LOAD) && load_valid;
  assign last_wr  = wr_ptr_q == PW'(DEPTH - 1);
  assign last_grp = g_q == IW'(NG - 1);

  // Next-state, issue datapath and result pipeline
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    g_d       = g_q;
    tag_d     = 1'b0;
    tag_idx_d = '0;
    for (int k = 0; k < 4; k++) begin
      pu_in_d[k] = '0;
      pu_w_d[k]  = '0;
    end
    p1_d     = tag_q;
    p1_idx_d = tag_q ? tag_idx_q : '0;
    p2_d     = p1_q;
    p2_idx_d = p1_q ? p1_idx_q : '0;

    unique case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          if (last_wr) begin
            wr_ptr_d = '0;
            state_d  = S_READY;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_READY: begin
        if (start) begin
          g_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        for (int k = 0; k < 4; k++) begin
          pu_in_d[k] = in_mem_q[PW'(4 * int'(g_q) + k)];
          pu_w_d[k]  = wt_mem_q[PW'(4 * int'(g_q) + k)];
        end
        tag_d     = 1'b1;
        tag_idx_d = g_q;
        if (last_grp) begin
          g_d     = '0;
          state_d = S_DRAIN;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // last result is on res_data this cycle and nothing follows it
        if (!tag_q && !p1_q && p2_q) state_d = S_DONE;
      end
      S_DONE: begin
        wr_ptr_d = '0;
        state_d  = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase

    done_d = state_d == S_DONE;
    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      wr_ptr_q  <= '0;
      g_q       <= '0;
      tag_q     <= 1'b0;
      tag_idx_q <= '0;
      p1_q      <= 1'b0;
      p1_idx_q  <= '0;
      p2_q      <= 1'b0;
      p2_idx_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        pu_in_q[k] <= '0;
        pu_w_q[k]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      g_q       <= g_d;
      tag_q     <= tag_d;
      tag_idx_q <= tag_idx_d;
      p1_q      <= p1_d;
      p1_idx_q  <= p1_idx_d;
      p2_q      <= p2_d;
      p2_idx_q  <= p2_idx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      for (int k = 0; k < 4; k++) begin
        pu_in_q[k] <= pu_in_d[k];
        pu_w_q[k]  <= pu_w_d[k];
      end
    end
  end

  // Pair buffer; contents survive reset and are overwritten per batch
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      in_mem_q[wr_ptr_q] <= load_data;
      wt_mem_q[wr_ptr_q] <= load_weight;
    end
  end

  assign load_ready = (state_q == S_LOAD) && !rst;
  assign busy       = busy_q;
  assign done       = done_q;
  assign res_valid  = p2_q;
  assign res_index  = p2_idx_q;
  assign res_data   = p2_q ? pu_out : 12'd0;

  assign pu_in1 = pu_in_q[0];
  assign pu_in2 = pu_in_q[1];
  assign pu_in3 = pu_in_q[2];
  assign pu_in4 = pu_in_q[3];
  assign pu_w1  = pu_w_q[0];
  assign pu_w2  = pu_w_q[1];
  assign pu_w3  = pu_w_q[2];
  assign pu_w4  = pu_w_q[3];

endmodule

// File: tb/tb_pu4_feeder.sv
// Directed bench for pu4_feeder with a 2-cycle sum-of-products PU model.
module tb_pu4_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_data;
  logic [4:0]  load_weight;
  logic        start;
  logic        busy;
  logic [4:0]  pu_in1, pu_in2, pu_in3, pu_in4;
  logic [4:0]  pu_w1, pu_w2, pu_w3, pu_w4;
  logic [11:0] pu_out;
  logic        res_valid;
  logic [11:0] res_data;
  logic [0:0]  res_index;
  logic        done;

  logic [11:0] s1;

  int n_chk = 0;
  int n_err = 0;

  int          res_cnt = 0;
  int          done_cnt = 0;
  int          ridx [16];
  logic [11:0] rdat [16];

  pu4_feeder #(.DEPTH(8), .W(5)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_weight(load_weight),
    .start(start), .busy(busy),
    .pu_in1(pu_in1), .pu_in2(pu_in2), .pu_in3(pu_in3), .pu_in4(pu_in4),
    .pu_w1(pu_w1), .pu_w2(pu_w2), .pu_w3(pu_w3), .pu_w4(pu_w4),
    .pu_out(pu_out),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= 12'(pu_in1) * 12'(pu_w1) + 12'(pu_in2) * 12'(pu_w2)
        + 12'(pu_in3) * 12'(pu_w3) + 12'(pu_in4) * 12'(pu_w4);
    pu_out <= s1;
  end

  always @(negedge clk) begin
    if (res_valid && res_cnt < 16) begin
      ridx[res_cnt] = int'(res_index);
      rdat[res_cnt] = res_data;
      res_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {pu_in1, pu_in2, pu_in3, pu_in4, pu_w1, pu_w2, pu_w3, pu_w4,
            res_valid, res_data, res_index, done, busy};
  endfunction

  task automatic load_batch(input logic [4:0] w, input bit same);
    for (int i = 0; i < 8; i++) begin
      load_valid  = 1'b1;
      load_data   = same ? w : 5'(i + 1);
      load_weight = w;
      tick();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_valid = 0; load_data = 0; load_weight = 0; start = 0;
    tick(); tick();
    check("rst_outs", outs(), 64'd0);
    check("rst_ready", 64'(load_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(load_ready), 64'd1);

    // start in LOAD is ignored
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_load_busy", 64'(busy), 64'd0);
    check("start_in_load_ready", 64'(load_ready), 64'd1);

    // toggled load_valid
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_data = 5'(i + 1); load_weight = 5'd2;
      tick();
      load_valid = 1'b0;
      if (i == 6) check("ready_before_last", 64'(load_ready), 64'd1);
      if (i == 7) check("ready_drop", 64'(load_ready), 64'd0);
      tick();
    end
    // 9th pulse ignored
    load_valid = 1'b1; load_data = 5'd30; load_weight = 5'd30;
    tick();
    load_valid = 1'b0;
    check("ninth_ignored", 64'(load_ready), 64'd0);
    check("ready_idle", outs(), 64'd0);

    // batch 1
    start = 1'b1; tick();
    check("issue_busy", 64'(busy), 64'd1);
    check("issue_first_zero", 64'({pu_in1, pu_in2, pu_in3, pu_in4}), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("grp0_in", 64'({pu_in1, pu_in2, pu_in3, pu_in4}),
          64'({5'd1, 5'd2, 5'd3, 5'd4}));
    check("grp0_w", 64'({pu_w1, pu_w2, pu_w3, pu_w4}),
          64'({5'd2, 5'd2, 5'd2, 5'd2}));
    tick();
    check("grp1_in", 64'({pu_in1, pu_in2, pu_in3, pu_in4}),
          64'({5'd5, 5'd6, 5'd7, 5'd8}));
    check("grp1_rv", 64'(res_valid), 64'd0);
    tick();
    check("drain_pu_zero", 64'({pu_in1, pu_in2, pu_in3, pu_in4}), 64'd0);
    check("res0", 64'({res_valid, res_index, res_data}),
          64'({1'b1, 1'b0, 12'd20}));
    tick();
    check("res1", 64'({res_valid, res_index, res_data}),
          64'({1'b1, 1'b1, 12'd52}));
    check("res1_done", 64'(done), 64'd0);
    tick();
    check("done_pulse", 64'({done, busy, res_valid, res_data}),
          64'({1'b1, 1'b0, 1'b0, 12'd0}));
    tick();
    check("done_gone", 64'({done, load_ready}), 64'({1'b0, 1'b1}));
    tick(); tick();
    check("b1_count", 64'(res_cnt), 64'd2);
    check("b1_done_cnt", 64'(done_cnt), 64'd1);

    // batch 2 back-to-back with (31,31)
    load_batch(5'd31, 1'b1);
    check("b2_ready_low", 64'(load_ready), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("b2_count", 64'(res_cnt), 64'd4);
    check("b2_r0", 64'({ridx[2][0], rdat[2]}), 64'({1'b0, 12'd3844}));
    check("b2_r1", 64'({ridx[3][0], rdat[3]}), 64'({1'b1, 12'd3844}));
    check("b2_done_cnt", 64'(done_cnt), 64'd2);

    // batch 3 aborted by reset after group 0
    load_batch(5'd2, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("b3_grp0", 64'({pu_in1, pu_in2, pu_in3, pu_in4}),
          64'({5'd1, 5'd2, 5'd3, 5'd4}));
    rst = 1'b1; tick();
    check("abort_outs", outs(), 64'd0);
    check("abort_ready", 64'(load_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_res", 64'(res_cnt), 64'd4);
    check("abort_no_done", 64'(done_cnt), 64'd2);
    check("abort_load", 64'({load_ready, busy}), 64'({1'b1, 1'b0}));
    check("abort_outs_idle", outs(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pu4_feeder.md
PU4_FEEDER -- requirements
Module: pu4_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of input/weight pairs per batch (multiple of 4, >= 4).
REQ-002 SHALL have parameter W, default 5, input and weight word width.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 load_valid  input  1  load word offered; load_ready  output  1  feeder accepts a load word.
REQ-006 load_data  input  W  input word; load_weight  input  W  weight word paired with load_data.
REQ-007 start  input  1  begin issuing the loaded batch; busy  output  1  high in ISSUE and DRAIN.
REQ-008 pu_in1..pu_in4  output  W each  registered input words to the PU.
REQ-009 pu_w1..pu_w4  output  W each  registered weight words to the PU.
REQ-010 pu_out  input  12  PU result, valid 2 cycles after its group appears on pu_in*/pu_w*.
REQ-011 res_valid  output  1  res_data holds a group result.
REQ-012 res_data  output  12  result; res_index  output  clog2(DEPTH/4) (min 1)  group number of the result.
REQ-013 done  output  1  one-cycle pulse marking batch completion.

Function
REQ-014 SHALL implement states LOAD, READY, ISSUE, DRAIN, DONE.
REQ-015 LOAD: load_ready=1; each cycle with load_valid=1 writes the pair to buffer[wr_ptr] and increments wr_ptr.
REQ-016 The write of pair DEPTH-1 SHALL move the state to READY; load_ready=0 in every state except LOAD.
REQ-017 READY: start=1 moves to ISSUE; group pointer g cleared to 0.
REQ-018 start SHALL be ignored in every state except READY; load_valid SHALL be ignored outside LOAD.
REQ-019 ISSUE: each clock edge loads group g (pairs 4g..4g+3, pair 4g+k onto pu_in(k+1)/pu_w(k+1)) into the output registers, tags it valid, and increments g.
REQ-020 Groups SHALL issue on consecutive cycles with no bubbles; after group DEPTH/4-1 the state moves to DRAIN.
REQ-021 pu_in*/pu_w* SHALL be 0 in every cycle that does not carry a tagged group.
REQ-022 A 2-stage valid/index pipeline SHALL follow each group, so that res_valid=1 and res_index=g exactly 2 cycles after group g appears on pu_in*.
REQ-023 res_data SHALL equal pu_out when res_valid=1 and 0 otherwise.
REQ-024 DRAIN: when the valid pipeline is empty and the last result has been presented, the state moves to DONE.
REQ-025 DONE lasts one cycle with done=1, then the state returns to LOAD with wr_ptr=0.
REQ-026 busy=1 in ISSUE and DRAIN only.
REQ-027 Each batch SHALL produce exactly DEPTH/4 res_valid pulses, in index order 0..DEPTH/4-1.
REQ-028 Buffer contents are not cleared between batches; a new batch overwrites all DEPTH entries before READY.

Reset
REQ-029 rst=1 at an edge SHALL set the state to LOAD and clear wr_ptr, g, and the valid pipeline.
REQ-030 rst=1 at an edge SHALL clear all output registers, so that pu_in*, pu_w*, res_valid, res_data, res_index, done, and busy are 0 and load_ready=0 while rst=1.
REQ-031 Reset during ISSUE or DRAIN SHALL abort the batch: no further res_valid and no done pulse.

Verification
REQ-032 Load pairs (i+1, 2) for i=0..7, start -> pu_in1..4=1,2,3,4 for one cycle, then 5,6,7,8; all pu_w*=2; res_valid with index 0 two cycles later, then index 1; done pulses one cycle after the index-1 result.
REQ-033 Connect a PU model (sum of in*w, 2-cycle latency) with the REQ-032 data -> res_data=20, then 52.
REQ-034 Toggle load_valid 1,0,1,... during LOAD -> exactly 8 writes; load_ready drops the cycle after the 8th write; a 9th load_valid pulse is ignored.
REQ-035 Pulse start during LOAD and during ISSUE -> no effect; the batch issues only once and produces 2 results.
REQ-036 Assert rst the cycle after group 0 issues -> no res_valid afterwards, no done, state LOAD, all outputs 0.
REQ-037 Run two batches back-to-back, the second with all pairs (31,31) -> second batch yields res_data=3844 twice with indices 0 and 1.
